// File: rtl/spi_responder_pkg.sv
// Shared constants and state encoding for the SPI register-file responder.
package spi_responder_pkg;

    localparam int unsigned BYTE_BITS   = 8;
    localparam int unsigned CNT_BITS    = 3;

    localparam logic [7:0]  CMD_WRITE   = 8'h0A;
    localparam logic [7:0]  CMD_READ    = 8'h0B;

    localparam logic [7:0]  ID_BYTE0    = 8'hAD;
    localparam logic [7:0]  ID_BYTE1    = 8'h1D;
    localparam logic [7:0]  ID_BYTE2    = 8'hF2;
    localparam int unsigned ID_ADDR0    = 0;
    localparam int unsigned ID_ADDR1    = 1;
    localparam int unsigned ID_ADDR2    = 2;

    localparam int unsigned AXIS_X_ADDR = 8;
    localparam int unsigned AXIS_Y_ADDR = 9;
    localparam int unsigned AXIS_Z_ADDR = 10;
    localparam int unsigned AXIS_REGS   = 3;

    localparam int unsigned WR_BASE     = 32;
    localparam int unsigned WR_LAST     = 63;
    localparam int unsigned WR_DEPTH    = 32;
    localparam int unsigned WR_IDX_BITS = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Synchronizes CS/SCLK/MOSI into the system clock domain and flags their edges.
module spi_input_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cs_i,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic cs_o,
    output logic mosi_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic cs_fall_o,
    output logic cs_rise_o
);

    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic cs_prev_q, sclk_prev_q;
    logic mosi_q, sclk_rise_q, sclk_fall_q, cs_fall_q, cs_rise_q;
    logic cs_s, sclk_s;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];

    // MOSI is registered alongside the edge flags so a rise sees the matching data bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            mosi_q      <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
        end else begin
            cs_sync_q   <= (cs_sync_q << 1) | SYNC_STAGES'(cs_i);
            sclk_sync_q <= (sclk_sync_q << 1) | SYNC_STAGES'(sclk_i);
            mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(mosi_i);
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
            sclk_rise_q <= sclk_s & ~sclk_prev_q;
            sclk_fall_q <= ~sclk_s & sclk_prev_q;
            cs_fall_q   <= ~cs_s & cs_prev_q;
            cs_rise_q   <= cs_s & ~cs_prev_q;
        end
    end

    assign cs_o        = cs_s;
    assign mosi_o      = mosi_q;
    assign sclk_rise_o = sclk_rise_q;
    assign sclk_fall_o = sclk_fall_q;
    assign cs_fall_o   = cs_fall_q;
    assign cs_rise_o   = cs_rise_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder with a byte register file: ID bytes, axis samples and a writable window.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cs_i,
    input  logic                 sclk_i,
    input  logic                 mosi_i,
    output logic                 miso_o,
    input  logic                 sample_valid_i,
    input  logic [7:0]           sample_x_i,
    input  logic [7:0]           sample_y_i,
    input  logic [7:0]           sample_z_i,
    output logic                 wr_strobe_o,
    output logic [ADDR_BITS-1:0] wr_addr_o,
    output logic [7:0]           wr_data_o,
    output logic                 busy_o
);

    logic cs_s, mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

    spi_input_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cs_i       (cs_i),
        .sclk_i     (sclk_i),
        .mosi_i     (mosi_i),
        .cs_o       (cs_s),
        .mosi_o     (mosi_s),
        .sclk_rise_o(sclk_rise),
        .sclk_fall_o(sclk_fall),
        .cs_fall_o  (cs_fall),
        .cs_rise_o  (cs_rise)
    );

    state_t                 state_q, state_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [BYTE_BITS-2:0]   rx_q, rx_d;
    logic [BYTE_BITS-1:0]   sh_q, sh_d;
    logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
    logic                   cmd_rd_q, cmd_rd_d;
    logic                   miso_q, miso_d;
    logic                   wr_strobe_q, wr_strobe_d;
    logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic                   busy_q, busy_d;
    logic [7:0]             wregs_q [WR_DEPTH];
    logic [7:0]             wregs_d [WR_DEPTH];
    logic [7:0]             axis_q  [AXIS_REGS];
    logic [7:0]             axis_d  [AXIS_REGS];

    logic [BYTE_BITS-1:0]   rx_next;
    logic [ADDR_BITS-1:0]   ptr_inc, rd_addr;
    logic [7:0]             rd_data;
    logic                   byte_done, wr_hit;

    assign rx_next   = {rx_q, mosi_s};
    assign ptr_inc   = ptr_q + ADDR_BITS'(1);
    assign byte_done = sclk_rise && (cnt_q == CNT_BITS'(7));
    assign wr_hit    = (32'(ptr_q) >= WR_BASE) && (32'(ptr_q) <= WR_LAST);

    // Byte fetched for the next read: the freshly received address, or the next burst slot.
    always_comb begin
        rd_addr = (state_q == ST_ADDR) ? ADDR_BITS'(rx_next) : ptr_inc;
        rd_data = '0;
        if (32'(rd_addr) == ID_ADDR0) begin
            rd_data = ID_BYTE0;
        end else if (32'(rd_addr) == ID_ADDR1) begin
            rd_data = ID_BYTE1;
        end else if (32'(rd_addr) == ID_ADDR2) begin
            rd_data = ID_BYTE2;
        end else if (32'(rd_addr) == AXIS_X_ADDR) begin
            rd_data = axis_q[0];
        end else if (32'(rd_addr) == AXIS_Y_ADDR) begin
            rd_data = axis_q[1];
        end else if (32'(rd_addr) == AXIS_Z_ADDR) begin
            rd_data = axis_q[2];
        end else if ((32'(rd_addr) >= WR_BASE) && (32'(rd_addr) <= WR_LAST)) begin
            rd_data = wregs_q[rd_addr[WR_IDX_BITS-1:0]];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        sh_d        = sh_q;
        ptr_d       = ptr_q;
        cmd_rd_d    = cmd_rd_q;
        miso_d      = miso_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        busy_d      = ~cs_s;
        wregs_d     = wregs_q;
        axis_d      = axis_q;

        if (sample_valid_i) begin
            axis_d[0] = sample_x_i;
            axis_d[1] = sample_y_i;
            axis_d[2] = sample_z_i;
        end

        // A deasserted CS drops any partial byte before it can be committed.
        if (cs_s || cs_rise) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
        end else begin
            if (state_q != ST_RDATA) begin
                miso_d = 1'b0;
            end
            if (sclk_rise && (state_q != ST_IDLE)) begin
                rx_d  = rx_next[BYTE_BITS-2:0];
                cnt_d = cnt_q + CNT_BITS'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d = ST_CMD;
                        cnt_d   = '0;
                    end
                end
                ST_CMD: begin
                    if (byte_done) begin
                        cmd_rd_d = (rx_next == CMD_READ);
                        state_d  = ((rx_next == CMD_READ) || (rx_next == CMD_WRITE)) ? ST_ADDR
                                                                                     : ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    if (byte_done) begin
                        ptr_d = rd_addr;
                        if (cmd_rd_q) begin
                            state_d = ST_RDATA;
                            sh_d    = rd_data;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (sclk_fall) begin
                        miso_d = sh_q[7];
                        sh_d   = {sh_q[6:0], 1'b0};
                    end
                    if (byte_done) begin
                        ptr_d = ptr_inc;
                        sh_d  = rd_data;
                    end
                end
                ST_WDATA: begin
                    if (byte_done) begin
                        if (wr_hit) begin
                            wregs_d[ptr_q[WR_IDX_BITS-1:0]] = rx_next;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = ptr_q;
                            wr_data_d   = rx_next;
                        end
                        ptr_d = ptr_inc;
                    end
                end
                ST_IGNORE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            sh_q        <= '0;
            ptr_q       <= '0;
            cmd_rd_q    <= 1'b0;
            miso_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            wregs_q     <= '{default: '0};
            axis_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            sh_q        <= sh_d;
            ptr_q       <= ptr_d;
            cmd_rd_q    <= cmd_rd_d;
            miso_q      <= miso_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            wregs_q     <= wregs_d;
            axis_q      <= axis_d;
        end
    end

    assign miso_o      = miso_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: an SPI master model driving a 64-byte reference memory.
module tb_spi_responder;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst, cs, sclk, mosi, sample_valid;
    logic [7:0] sx, sy, sz;
    logic       miso, wr_strobe, busy;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    int errors = 0;
    int checks = 0;
    int miso_hi = 0;

    logic [7:0]  mem [64];
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    logic [13:0] got_wr [$];
    logic [13:0] exp_wr [$];

    always #4 clk = ~clk;

    spi_responder dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cs_i          (cs),
        .sclk_i        (sclk),
        .mosi_i        (mosi),
        .miso_o        (miso),
        .sample_valid_i(sample_valid),
        .sample_x_i    (sx),
        .sample_y_i    (sy),
        .sample_z_i    (sz),
        .wr_strobe_o   (wr_strobe),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .busy_o        (busy)
    );

    always @(negedge clk) begin
        if (wr_strobe) got_wr.push_back({wr_addr, wr_data});
        if (miso) miso_hi++;
    end

    function automatic void model_reset();
        foreach (mem[i]) mem[i] = 8'h00;
        mem[0] = 8'hAD;
        mem[1] = 8'h1D;
        mem[2] = 8'hF2;
    endfunction

    function automatic void model_write(input int a, input logic [7:0] d);
        if (a >= 32 && a <= 63) begin
            mem[a] = d;
            exp_wr.push_back({6'(a), d});
        end
    endfunction

    task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_start();
        @(negedge clk);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic spi_txn();
        logic [7:0] r;
        rx_q.delete();
        cs_start();
        foreach (tx_q[i]) begin
            xfer_bits(tx_q[i], 8, r);
            rx_q.push_back(r);
        end
        cs_end();
    endtask

    task automatic pulse_sample(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        sx = x; sy = y; sz = z;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        mem[8] = x; mem[9] = y; mem[10] = z;
    endtask

    task automatic test_reset();
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rst_miso: got %b expected 0", miso); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b expected 0", wr_strobe); end
        checks++; if (wr_addr !== 6'h00) begin errors++; $display("FAIL rst_addr: got %h expected 00", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b expected 0", busy); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL post_rst_miso: got %b expected 0", miso); end
    endtask

    task automatic test_id_read();
        int gb = got_wr.size();
        logic [7:0] exp [3] = '{8'hAD, 8'h1D, 8'hF2};
        tx_q = '{8'h0B, 8'h00, 8'h00, 8'h00, 8'h00};
        spi_txn();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rx_q[2+k] !== exp[k]) begin
                errors++; $display("FAIL id_byte%0d: got %h expected %h", k, rx_q[2+k], exp[k]);
            end
        end
        checks++;
        if (got_wr.size() != gb) begin
            errors++; $display("FAIL id_no_strobe: got %0d strobes expected 0", got_wr.size() - gb);
        end
    endtask

    task automatic test_write_read();
        int gb = got_wr.size();
        cs_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_active: got %b expected 1", busy); end
        cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        tx_q = '{8'h0A, 8'h2D, 8'h0A};
        spi_txn();
        model_write(8'h2D, 8'h0A);
        checks++;
        if (got_wr.size() - gb != 1) begin
            errors++; $display("FAIL wr_count: got %0d expected 1", got_wr.size() - gb);
        end else begin
            checks++;
            if (got_wr[gb] !== {6'h2D, 8'h0A}) begin
                errors++; $display("FAIL wr_addr_data: got %h expected %h", got_wr[gb], {6'h2D, 8'h0A});
            end
        end
        tx_q = '{8'h0B, 8'h2D, 8'h00};
        spi_txn();
        checks++; if (rx_q[2] !== 8'h0A) begin errors++; $display("FAIL rd_2d: got %h expected 0a", rx_q[2]); end
    endtask

    task automatic test_sample();
        logic [7:0] ra, rb, b0, b1;
        pulse_sample(8'h12, 8'h34, 8'h56);
        tx_q = '{8'h0B, 8'h08, 8'h00, 8'h00, 8'h00};
        spi_txn();
        checks++; if (rx_q[2] !== 8'h12) begin errors++; $display("FAIL axis_x: got %h expected 12", rx_q[2]); end
        checks++; if (rx_q[3] !== 8'h34) begin errors++; $display("FAIL axis_y: got %h expected 34", rx_q[3]); end
        checks++; if (rx_q[4] !== 8'h56) begin errors++; $display("FAIL axis_z: got %h expected 56", rx_q[4]); end
        cs_start();
        xfer_bits(8'h0B, 8, ra);
        xfer_bits(8'h08, 8, ra);
        xfer_bits(8'h00, 3, ra);
        pulse_sample(8'h9A, 8'hBC, 8'hDE);
        xfer_bits(8'h00, 5, rb);
        b0 = {ra[2:0], rb[4:0]};
        xfer_bits(8'h00, 8, b1);
        cs_end();
        checks++; if (b0 !== 8'h12) begin errors++; $display("FAIL torn_read: got %h expected 12", b0); end
        checks++; if (b1 !== 8'hBC) begin errors++; $display("FAIL new_sample: got %h expected bc", b1); end
    endtask

    task automatic test_drop_and_wrap();
        int gb = got_wr.size();
        tx_q = '{8'h0A, 8'h00, 8'hFF};
        spi_txn();
        checks++;
        if (got_wr.size() != gb) begin
            errors++; $display("FAIL drop_strobe: got %0d strobes expected 0", got_wr.size() - gb);
        end
        tx_q = '{8'h0B, 8'h00, 8'h00};
        spi_txn();
        checks++; if (rx_q[2] !== 8'hAD) begin errors++; $display("FAIL id_immutable: got %h expected ad", rx_q[2]); end
        gb = got_wr.size();
        tx_q = '{8'h0A, 8'h3F, 8'hC3, 8'h77};
        spi_txn();
        model_write(63, 8'hC3);
        checks++;
        if (got_wr.size() - gb != 1) begin
            errors++; $display("FAIL wrap_count: got %0d expected 1", got_wr.size() - gb);
        end else begin
            checks++;
            if (got_wr[gb] !== {6'h3F, 8'hC3}) begin
                errors++; $display("FAIL wrap_write: got %h expected %h", got_wr[gb], {6'h3F, 8'hC3});
            end
        end
        tx_q = '{8'h0B, 8'h3F, 8'h00, 8'h00};
        spi_txn();
        checks++; if (rx_q[2] !== 8'hC3) begin errors++; $display("FAIL rd_3f: got %h expected c3", rx_q[2]); end
        checks++; if (rx_q[3] !== 8'hAD) begin errors++; $display("FAIL rd_wrap: got %h expected ad", rx_q[3]); end
    endtask

    task automatic test_abort();
        int gb;
        logic [7:0] r;
        tx_q = '{8'h0A, 8'h25, 8'h77};
        spi_txn();
        model_write(8'h25, 8'h77);
        gb = got_wr.size();
        cs_start();
        xfer_bits(8'h0A, 8, r);
        xfer_bits(8'h25, 8, r);
        xfer_bits(8'hFF, 5, r);
        cs_end();
        checks++;
        if (got_wr.size() != gb) begin
            errors++; $display("FAIL abort_strobe: got %0d strobes expected 0", got_wr.size() - gb);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        tx_q = '{8'h0B, 8'h25, 8'h00};
        spi_txn();
        checks++; if (rx_q[2] !== mem[8'h25]) begin errors++; $display("FAIL abort_unchanged: got %h expected %h", rx_q[2], mem[8'h25]); end
    endtask

    task automatic test_bad_cmd();
        int gb = got_wr.size();
        int hi = miso_hi;
        tx_q = '{8'h55, 8'hFF, 8'hFF};
        spi_txn();
        checks++; if (miso_hi != hi) begin errors++; $display("FAIL ignore_miso: got %0d high cycles expected 0", miso_hi - hi); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rx_q[k] !== 8'h00) begin errors++; $display("FAIL ignore_byte%0d: got %h expected 00", k, rx_q[k]); end
        end
        checks++;
        if (got_wr.size() != gb) begin
            errors++; $display("FAIL ignore_strobe: got %0d strobes expected 0", got_wr.size() - gb);
        end
    endtask

    task automatic test_reset_mid();
        int gb;
        logic [7:0] r;
        tx_q = '{8'h0A, 8'h30, 8'h5A};
        spi_txn();
        model_write(8'h30, 8'h5A);
        gb = got_wr.size();
        cs_start();
        xfer_bits(8'h0A, 8, r);
        xfer_bits(8'h30, 8, r);
        xfer_bits(8'hA5, 6, r);
        rst = 1'b1; cs = 1'b1; sclk = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2 * HALF) @(negedge clk);
        checks++;
        if (got_wr.size() != gb) begin
            errors++; $display("FAIL rstmid_strobe: got %0d strobes expected 0", got_wr.size() - gb);
        end
        tx_q = '{8'h0B, 8'h30, 8'h00, 8'h00};
        spi_txn();
        checks++; if (rx_q[2] !== 8'h00) begin errors++; $display("FAIL rstmid_reg: got %h expected 00", rx_q[2]); end
        checks++; if (rx_q[3] !== 8'h00) begin errors++; $display("FAIL rstmid_next: got %h expected 00", rx_q[3]); end
    endtask

    task automatic test_random();
        int gb = got_wr.size();
        int eb = exp_wr.size();
        for (int it = 0; it < 12; it++) begin
            logic [7:0] a;
            logic [7:0] d;
            int n;
            a = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 3);
            tx_q = '{8'h0A, a};
            for (int k = 0; k < n; k++) begin
                d = 8'($urandom);
                tx_q.push_back(d);
                model_write((int'(a) + k) % 64, d);
            end
            spi_txn();
            tx_q = '{8'h0B, a};
            for (int k = 0; k <= n; k++) tx_q.push_back(8'($urandom));
            spi_txn();
            for (int k = 0; k <= n; k++) begin
                checks++;
                if (rx_q[2+k] !== mem[(int'(a) + k) % 64]) begin
                    errors++;
                    $display("FAIL rand_read a=%h k=%0d: got %h expected %h", a, k, rx_q[2+k], mem[(int'(a) + k) % 64]);
                end
            end
        end
        checks++;
        if (got_wr.size() - gb != exp_wr.size() - eb) begin
            errors++; $display("FAIL rand_wr_count: got %0d expected %0d", got_wr.size() - gb, exp_wr.size() - eb);
        end else begin
            for (int k = 0; k < exp_wr.size() - eb; k++) begin
                checks++;
                if (got_wr[gb+k] !== exp_wr[eb+k]) begin
                    errors++; $display("FAIL rand_wr%0d: got %h expected %h", k, got_wr[gb+k], exp_wr[eb+k]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        sample_valid = 1'b0; sx = 8'h00; sy = 8'h00; sz = 8'h00;
        model_reset();
        repeat (5) @(negedge clk);
        test_reset();
        test_id_read();
        test_write_read();
        test_sample();
        test_drop_and_wrap();
        test_abort();
        test_bad_cmd();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 6, register-file address width (64 bytes).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for CS/SCLK/MOSI.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: CLK input 1 (system clock, 125 MHz); RESET input 1 (async, active-high).
REQ-004 SHALL have CS input 1: chip select, active-low.
REQ-005 SHALL have SCLK input 1: SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-006 SHALL have MOSI input 1: serial data from master, MSB first.
REQ-007 SHALL have MISO output 1: serial data to master, MSB first.
REQ-008 SHALL have SAMPLE_VALID input 1: one-cycle load strobe for axis samples.
REQ-009 SHALL have SAMPLE_X, SAMPLE_Y, SAMPLE_Z inputs, 8 bits each: axis data loaded into regs 0x08/0x09/0x0A.
REQ-010 SHALL have WR_STROBE output 1: one-cycle pulse per accepted register write.
REQ-011 SHALL have WR_ADDR output ADDR_BITS and WR_DATA output 8: address and data of the accepted write, valid with WR_STROBE.
REQ-012 SHALL have BUSY output 1: high while the synchronized CS is low.

Function
REQ-013 SHALL pass CS, SCLK and MOSI through SYNC_STAGES flops and detect SCLK rise/fall and CS fall/rise in the CLK domain.
REQ-014 SHALL operate correctly for SCLK high and low phases each at least SYNC_STAGES+3 CLK cycles.
REQ-015 SHALL sample MOSI on each synchronized SCLK rising edge and update MISO only on synchronized SCLK falling edges.
REQ-016 SHALL implement states IDLE, CMD, ADDR, RDATA, WDATA and IGNORE.
REQ-017 IDLE -> CMD on CS fall, with the bit counter cleared.
REQ-018 CMD: after 8 bits, go to ADDR if the byte is 0x0A (write) or 0x0B (read); otherwise go to IGNORE.
REQ-019 ADDR: after 8 bits, latch the low ADDR_BITS as the pointer and go to RDATA or WDATA according to the command.
REQ-020 RDATA: load the pointed byte into the shift register when the 16th rising edge is sampled; drive its MSB on the following falling edge and the remaining bits on subsequent falling edges.
REQ-021 RDATA: after each 8 bits, increment the pointer and reload the shift register (burst read).
REQ-022 WDATA: after each 8 bits, write the byte if the pointer is in 0x20-0x3F, pulse WR_STROBE within 2 CLK cycles of the 8th rising edge, and increment the pointer (burst write).
REQ-023 Pointer increment SHALL wrap from 2^ADDR_BITS-1 to 0.
REQ-024 Writes to 0x00-0x1F SHALL be dropped: no register update and no WR_STROBE.
REQ-025 IGNORE: MISO held 0 until CS rises.
REQ-026 CS rise in any state SHALL return to IDLE within SYNC_STAGES+1 cycles, discard any partial byte without writing it, and force MISO to 0.
REQ-027 MISO SHALL be 0 in IDLE, CMD, ADDR and WDATA.
REQ-028 SAMPLE_VALID SHALL write SAMPLE_X/Y/Z into 0x08/0x09/0x0A in the same cycle regardless of state.
REQ-029 A byte already loaded into the read shift register SHALL NOT change if SAMPLE_VALID occurs mid-byte (no torn reads).
REQ-030 Registers 0x00/0x01/0x02 SHALL read 0xAD/0x1D/0xF2 (device ID) and SHALL be immutable.

Reset
REQ-031 On RESET: state IDLE, MISO 0, WR_STROBE 0, WR_ADDR 0, WR_DATA 0, BUSY 0, and synchronizers set to CS=1, SCLK=0, MOSI=0.
REQ-032 On RESET: regs 0x00-0x02 hold the ID values and all other registers are 0.
REQ-033 RESET asserted mid-transaction SHALL abort it, and no write SHALL occur.

Structure
REQ-034 A shared package SHALL hold the command opcodes 0x0A/0x0B, the ID bytes, the axis register addresses 0x08-0x0A, the writable-range base 0x20, and the state encoding.
REQ-035 The CS/SCLK/MOSI synchronizer-plus-edge-detector SHALL be one sub-module named spi_input_sync.

Verification
REQ-036 RESET, then read cmd 0x0B addr 0x00 with a 3-byte burst -> MISO returns 0xAD, 0x1D, 0xF2 and WR_STROBE never pulses.
REQ-037 Write 0x0A 0x2D 0x0A -> one WR_STROBE with WR_ADDR 0x2D and WR_DATA 0x0A; a following read of 0x2D returns 0x0A.
REQ-038 SAMPLE_VALID with X=0x12, Y=0x34, Z=0x56, then burst read from 0x08 -> 0x12, 0x34, 0x56; a second SAMPLE_VALID mid-byte leaves the current byte intact and the next byte shows the new value.
REQ-039 Write to 0x00 with data 0xFF -> no WR_STROBE and a read of 0x00 still returns 0xAD; burst write from 0x3F with 2 bytes -> writes 0x3F, then wraps to 0x00, which is dropped.
REQ-040 CS raised after 5 bits of a write data byte -> no WR_STROBE, the register is unchanged and the state returns to IDLE.
REQ-041 Command 0x55 -> MISO stays 0 for 24 clocks, with no writes.
